// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - region decode, sizing helpers and polarity constants for the VGA timing generator
package vga_timing_pkg;

  localparam logic        POL_ACTIVE_LOW  = 1'b0;
  localparam logic        POL_ACTIVE_HIGH = 1'b1;
  localparam int unsigned MAX_PIPE_DELAY  = 15;

  // Position of a counter within one axis of the raster, in scan order.
  typedef enum logic [1:0] {
    REGION_ACTIVE,
    REGION_FP,
    REGION_SYNC,
    REGION_BP
  } region_e;

  function automatic int unsigned axis_total(input int unsigned active,
                                             input int unsigned fp,
                                             input int unsigned sync,
                                             input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // Counter width for an axis; never below one bit so tiny rasters still elaborate.
  function automatic int unsigned count_width(input int unsigned total);
    return (total <= 2) ? 1 : int'($clog2(total));
  endfunction

  // Maps an axis position onto active / front porch / sync / back porch.
  function automatic region_e region_decode(input int unsigned pos,
                                            input int unsigned active,
                                            input int unsigned fp,
                                            input int unsigned sync);
    region_e r;
    if (pos < active) begin
      r = REGION_ACTIVE;
    end else if (pos < active + fp) begin
      r = REGION_FP;
    end else if (pos < active + fp + sync) begin
      r = REGION_SYNC;
    end else begin
      r = REGION_BP;
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_sync_delay_line.sv
// rtl/vga_sync_delay_line.sv - enabled shift register with asynchronous reset to a per-bit init vector
module vga_sync_delay_line #(
  parameter int unsigned      WIDTH = 1,
  parameter int unsigned      DEPTH = 0,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk_i, rst_i, en_i};
    assign data_o      = data_i;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift only on enabled clocks so stalls freeze the whole pipeline in step.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          stage_q[i] <= INIT;
        end
      end else if (en_i) begin
        stage_q[0] <= data_i;
        for (int i = 1; i < int'(DEPTH); i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign data_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator; VGA_TIMING_FRAME_CNT_EN adds o_Frame_Count
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter logic        HS_POL     = POL_ACTIVE_LOW,
  parameter logic        VS_POL     = POL_ACTIVE_LOW,
  parameter int unsigned PIPE_DELAY = 0,
  localparam int unsigned H_TOTAL   = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int unsigned V_TOTAL   = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int unsigned CW        = count_width(H_TOTAL),
  localparam int unsigned RW        = count_width(V_TOTAL)
) (
  input  logic          i_Clk,
  input  logic          i_Rst,
  input  logic          i_En,
  output logic          o_HSync,
  output logic          o_VSync,
  output logic          o_DE,
  output logic          o_Frame_Start,
  output logic [CW-1:0] o_Col_Count,
`ifdef VGA_TIMING_FRAME_CNT_EN
  output logic [RW-1:0] o_Row_Count,
  output logic [7:0]    o_Frame_Count
`else
  output logic [RW-1:0] o_Row_Count
`endif
);

  if (H_SYNC == 0 || V_SYNC == 0 || H_ACTIVE == 0 || V_ACTIVE == 0 ||
      PIPE_DELAY > MAX_PIPE_DELAY) begin : g_cfg_error
    $error("vga_timing_gen: invalid timing configuration");
  end

  localparam logic [CW-1:0] COL_LAST = CW'(H_TOTAL - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(V_TOTAL - 1);

  // Packed output word: {frame_start, de, vsync, hsync, row, col}.
  localparam int unsigned    OW       = 4 + CW + RW;
  localparam logic [OW-1:0]  OUT_INIT = {1'b0, 1'b0, ~VS_POL, ~HS_POL, {RW{1'b0}}, {CW{1'b0}}};

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  region_e       h_region, v_region;
  logic          hs_d, vs_d, de_d, fs_d;
  logic [OW-1:0] out_q, out_d, out_dly;

  // Raster counters: column wraps every line, row steps on each column wrap.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (i_En) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d = '0;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Counter state; reset parks the raster at (0,0) ready for the first enabled clock.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Decode the current position into sync, data-enable and frame strobe levels.
  always_comb begin
    h_region = region_decode(32'(col_q), H_ACTIVE, H_FP, H_SYNC);
    v_region = region_decode(32'(row_q), V_ACTIVE, V_FP, V_SYNC);
    hs_d     = (h_region == REGION_SYNC) ? HS_POL : ~HS_POL;
    vs_d     = (v_region == REGION_SYNC) ? VS_POL : ~VS_POL;
    de_d     = (h_region == REGION_ACTIVE) && (v_region == REGION_ACTIVE);
    fs_d     = (col_q == '0) && (row_q == '0) && i_En;
    out_d    = {fs_d, de_d, vs_d, hs_d, row_q, col_q};
  end

  // First output register; holds on stalls so outputs stay aligned with the frozen counters.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      out_q <= OUT_INIT;
    end else if (i_En) begin
      out_q <= out_d;
    end
  end

  vga_sync_delay_line #(
    .WIDTH (OW),
    .DEPTH (PIPE_DELAY),
    .INIT  (OUT_INIT)
  ) u_out_delay (
    .clk_i  (i_Clk),
    .rst_i  (i_Rst),
    .en_i   (i_En),
    .data_i (out_q),
    .data_o (out_dly)
  );

  assign {o_Frame_Start, o_DE, o_VSync, o_HSync, o_Row_Count, o_Col_Count} = out_dly;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [7:0] frame_cnt_dly;

  // Frame counter steps with the strobe entering the output register, so both leave together.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (fs_d) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  // Frame counter state, wrapping modulo 256.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  vga_sync_delay_line #(
    .WIDTH (8),
    .DEPTH (PIPE_DELAY),
    .INIT  (8'd0)
  ) u_frame_cnt_delay (
    .clk_i  (i_Clk),
    .rst_i  (i_Rst),
    .en_i   (i_En),
    .data_i (frame_cnt_q),
    .data_o (frame_cnt_dly)
  );

  assign o_Frame_Count = frame_cnt_dly;
`endif

endmodule
